// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite-memory read arbiter: element IDs,
// default bus widths, FSM state encoding and the element legality check.
package sprite_pkg;

  // Sprite element IDs as seen on the element-select bus
  localparam int unsigned ELEM_FRUIT      = 1;
  localparam int unsigned ELEM_HEART      = 2;
  localparam int unsigned ELEM_SNAKE      = 3;
  localparam int unsigned ELEM_BACKGROUND = 4;
  localparam int unsigned ELEM_BLOCK      = 5;
  localparam int unsigned NUM_ELEMENTS    = 5;

  // Default widths of the sprite-memory interface
  localparam int unsigned ELEM_W_DEF = 3;
  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // Element 0 means "nothing"; IDs above the element count do not exist.
  function automatic logic elem_is_legal(input int unsigned elem,
                                         input int unsigned num_elements);
    return (elem != 0) && (elem <= num_elements);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker. Searches from ptr+1 (mod NUM_REQ) upward and
// returns the first asserted request.
//   req      : request vector
//   ptr      : index of the most recent winner
//   gnt_c    : one-hot winner (combinational)
//   winner_c : winner index (combinational)
//   any_c    : 1 when some request won (combinational)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt_c,
  output logic [$clog2(NUM_REQ)-1:0] winner_c,
  output logic                       any_c
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] idx;

  // Walk the requesters in rotated order; the first hit locks the result.
  always_comb begin
    gnt_c    = '0;
    winner_c = '0;
    any_c    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!any_c && req[idx]) begin
        any_c      = 1'b1;
        gnt_c[idx] = 1'b1;
        winner_c   = idx;
      end
    end
  end

endmodule

// File: rtl/sprite_read_arbiter.sv
// Shares the single sprite-memory read port among several pixel requesters.
// One grant per clock (round-robin); each read carries a requester tag through
// the fixed memory latency and returns as a one-cycle response.
//   clk, reset      : clock, async active-low reset
//   enable          : 1 = grant new requests, 0 = stop granting and drain
//   req/req_element/req_address : per-requester request and packed payload
//   gnt             : one-hot grant (combinational)
//   mem_read_enable/mem_element/mem_address : registered memory read port
//   mem_dataout     : colour from memory, MEM_LATENCY cycles after the strobe
//   rsp_valid/rsp_id/rsp_err/rsp_data : registered response
//   idle            : registered, 1 when idle with nothing in flight
module sprite_read_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ELEM_W       = ELEM_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned NUM_ELEMENTS = sprite_pkg::NUM_ELEMENTS,
  parameter int unsigned MEM_LATENCY  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ELEM_W-1:0]   req_element,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        mem_read_enable,
  output logic [ELEM_W-1:0]           mem_element,
  output logic [ADDR_W-1:0]           mem_address,
  input  logic [DATA_W-1:0]           mem_dataout,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic                        rsp_err,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        idle
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  // Stage 0 is the issue cycle; the last stage lines up with mem_dataout.
  localparam int unsigned DEPTH = MEM_LATENCY + 1;

  arb_state_e          state;
  arb_state_e          state_next;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;
  logic                grant_c;
  logic [ELEM_W-1:0]   sel_element;
  logic [ADDR_W-1:0]   sel_address;
  logic                sel_legal;
  logic [DEPTH-1:0]    tag_vld;
  logic [DEPTH-1:0]    tag_err;
  logic [ID_W-1:0]     tag_id [DEPTH];
  logic                pipe_empty;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req      (req),
    .ptr      (rr_ptr),
    .gnt_c    (arb_gnt),
    .winner_c (arb_idx),
    .any_c    (arb_any)
  );

  // Payload of the current winner
  always_comb begin
    sel_element = '0;
    sel_address = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_element = req_element[i*ELEM_W +: ELEM_W];
        sel_address = req_address[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign sel_legal  = elem_is_legal(32'(sel_element), NUM_ELEMENTS);
  assign pipe_empty = ~|tag_vld;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and grant; grants only while running with enable still high
  always_comb begin
    state_next = state;
    gnt        = '0;
    grant_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (enable) begin
          gnt     = arb_gnt;
          grant_c = arb_any;
        end else if (pipe_empty) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (enable)          state_next = ST_RUN;
        else if (pipe_empty) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // idle follows the state being entered so it is high exactly while in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle <= 1'b1;
    end else begin
      idle <= (state_next == ST_IDLE);
    end
  end

  // Round-robin pointer: last winner, so requester 0 is first after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= ID_W'(NUM_REQ - 1);
    end else if (grant_c) begin
      rr_ptr <= arb_idx;
    end
  end

  // Memory issue; illegal elements are tagged but never strobe the memory
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_read_enable <= 1'b0;
      mem_element     <= '0;
      mem_address     <= '0;
    end else begin
      mem_read_enable <= grant_c & sel_legal;
      if (grant_c) begin
        mem_element <= sel_element;
        mem_address <= sel_address;
      end
    end
  end

  // Tag pipeline tracking each issue slot through the memory latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      tag_err <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) tag_id[k] <= '0;
    end else begin
      tag_vld <= {tag_vld[DEPTH-2:0], grant_c};
      tag_err <= {tag_err[DEPTH-2:0], grant_c & ~sel_legal};
      for (int unsigned k = DEPTH - 1; k > 0; k--) tag_id[k] <= tag_id[k-1];
      tag_id[0] <= grant_c ? arb_idx : '0;
    end
  end

  // Response register; all fields zero when no response is due
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_vld[DEPTH-1];
      rsp_id    <= tag_vld[DEPTH-1] ? tag_id[DEPTH-1] : '0;
      rsp_err   <= tag_vld[DEPTH-1] & tag_err[DEPTH-1];
      rsp_data  <= (tag_vld[DEPTH-1] && !tag_err[DEPTH-1]) ? mem_dataout : '0;
    end
  end

endmodule

// File: tb/tb_sprite_read_arbiter.sv
module tb_sprite_read_arbiter;

  localparam int NR = 4;
  localparam int EW = 3;
  localparam int AW = 10;
  localparam int DW = 12;
  localparam int L  = 2;
  localparam int HMAX = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NR-1:0]     req;
  logic [NR*EW-1:0]  req_element;
  logic [NR*AW-1:0]  req_address;
  logic [NR-1:0]     gnt;
  logic              mem_read_enable;
  logic [EW-1:0]     mem_element;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_dataout;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic              rsp_err;
  logic [DW-1:0]     rsp_data;
  logic              idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_read_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .req             (req),
    .req_element     (req_element),
    .req_address     (req_address),
    .gnt             (gnt),
    .mem_read_enable (mem_read_enable),
    .mem_element     (mem_element),
    .mem_address     (mem_address),
    .mem_dataout     (mem_dataout),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_err         (rsp_err),
    .rsp_data        (rsp_data),
    .idle            (idle)
  );

  // Sprite memory contents
  function automatic logic [11:0] color(input logic [2:0] e, input logic [9:0] a);
    if (e == 3'd1 && a == 10'h005) return 12'hF00;
    return {e, a[8:0]} ^ 12'h5A5;
  endfunction

  function automatic bit legal(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fixed-latency memory: data for a strobed read appears L cycles later;
  // unstrobed slots return junk so error responses must not pass it through.
  bit         mp_v [L];
  logic [11:0] mp_d [L];
  always @(posedge clk) begin
    for (int k = L - 1; k > 0; k--) begin
      mp_v[k] <= mp_v[k-1];
      mp_d[k] <= mp_d[k-1];
    end
    mp_v[0] <= mem_read_enable;
    mp_d[0] <= color(mem_element, mem_address);
  end
  assign mem_dataout = mp_v[L-1] ? mp_d[L-1] : 12'hABC;

  // Behavioural model: grant history per cycle since reset
  int         mcyc;
  int         mptr;
  bit         prev_en;
  bit         h_v [HMAX];
  int         h_id [HMAX];
  logic [2:0] h_e [HMAX];
  logic [9:0] h_a [HMAX];
  logic [2:0] last_e;
  logic [9:0] last_a;

  always @(negedge clk) begin
    int          win;
    int          g;
    logic [NR-1:0] eg;
    bit          exp_mre, ev, eerr, busy;
    int          eid;
    logic [11:0] edata;
    if (!reset) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_mem_read_enable", mem_read_enable, 0);
      chk("rst_mem_element", mem_element, 0);
      chk("rst_mem_address", mem_address, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_idle", idle, 1);
      mcyc = 0; mptr = NR - 1; prev_en = 1'b0; last_e = '0; last_a = '0;
    end else if (mcyc < HMAX) begin
      // Granting requires enable high in this and the previous cycle
      win = -1;
      eg  = '0;
      if (prev_en && enable)
        for (int k = 1; k <= NR; k++)
          if (win < 0 && req[(mptr + k) % NR]) win = (mptr + k) % NR;
      if (win >= 0) begin
        eg[win] = 1'b1;
        mptr    = win;
        h_e[mcyc] = req_element[win*EW +: EW];
        h_a[mcyc] = req_address[win*AW +: AW];
      end else begin
        h_e[mcyc] = '0;
        h_a[mcyc] = '0;
      end
      h_v[mcyc]  = (win >= 0);
      h_id[mcyc] = win;
      chk("gnt", gnt, eg);

      exp_mre = 1'b0;
      if (mcyc >= 1 && h_v[mcyc-1]) begin
        exp_mre = legal(h_e[mcyc-1]);
        last_e  = h_e[mcyc-1];
        last_a  = h_a[mcyc-1];
      end
      chk("mem_read_enable", mem_read_enable, exp_mre);
      chk("mem_element", mem_element, last_e);
      chk("mem_address", mem_address, last_a);

      g = mcyc - 2 - L;
      ev = 1'b0; eid = 0; eerr = 1'b0; edata = '0;
      if (g >= 0 && h_v[g]) begin
        ev    = 1'b1;
        eid   = h_id[g];
        eerr  = !legal(h_e[g]);
        edata = eerr ? 12'h000 : color(h_e[g], h_a[g]);
      end
      chk("rsp_valid", rsp_valid, ev);
      chk("rsp_id", rsp_id, eid);
      chk("rsp_err", rsp_err, eerr);
      chk("rsp_data", rsp_data, edata);

      busy = 1'b0;
      for (int j = mcyc - 2 - L; j <= mcyc - 2; j++)
        if (j >= 0 && h_v[j]) busy = 1'b1;
      chk("idle", idle, !prev_en && !busy);

      prev_en = enable;
      mcyc++;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [2:0] e, input logic [9:0] a);
    req_element[i*EW +: EW] = e;
    req_address[i*AW +: AW] = a;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; req = '0; req_element = '0; req_address = '0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("lit_reset_idle", idle, 1);
    chk("lit_reset_rsp_valid", rsp_valid, 0);
    next(); reset = 1'b1; enable = 1'b1;

    // Single read: requester 0, element 1, address 5
    next(); req = 4'b0001; set_slot(0, 3'd1, 10'h005);
    @(negedge clk); chk("t1_gnt", gnt, 4'b0001);
    next(); req = '0;
    @(negedge clk);
    chk("t1_mre", mem_read_enable, 1);
    chk("t1_elem", mem_element, 1);
    chk("t1_addr", mem_address, 10'h005);
    next(); next();
    @(negedge clk); chk("t1_rsp_early", rsp_valid, 0);
    next();
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_rsp_data", rsp_data, 12'hF00);
    repeat (6) next();

    // Illegal elements 0 and 6 on requester 2
    for (int k = 0; k < 6; k++) begin
      next();
      if (k == 0) begin req = 4'b0100; set_slot(2, 3'd0, 10'h077); end
      if (k == 1) set_slot(2, 3'd6, 10'h078);
      if (k == 2) req = '0;
      @(negedge clk);
      if (k < 2) chk("t2_gnt", gnt, 4'b0100);
      if (k == 1 || k == 2) chk("t2_mre", mem_read_enable, 0);
      if (k >= 4) begin
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_id", rsp_id, 2);
        chk("t2_rsp_err", rsp_err, 1);
        chk("t2_rsp_data", rsp_data, 0);
      end
    end
    repeat (6) next();

    // One background read on requester 3 moves the pointer to 3
    next(); req = 4'b1000; set_slot(3, 3'd4, 10'h100);
    @(negedge clk); chk("t3_gnt", gnt, 4'b1000);
    next(); req = '0;
    repeat (6) next();

    // Full contention for 8 cycles
    for (int i = 0; i < NR; i++) set_slot(i, 3'(i + 1), 10'(16 * i + 3));
    for (int k = 0; k < 12; k++) begin
      next();
      req = (k < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (k < 8) chk("t4_gnt", gnt, 32'(1) << (k % 4));
      if (k >= 4) begin
        chk("t4_rsp_valid", rsp_valid, 1);
        chk("t4_rsp_id", rsp_id, (k - 4) % 4);
      end
    end
    repeat (6) next();

    // Drain: three grants, enable drops, then resume
    for (int k = 0; k < 12; k++) begin
      next();
      enable = (k < 3 || k >= 9);
      req = (k < 3) ? 4'b0111 : ((k <= 10) ? 4'b1000 : 4'b0000);
      @(negedge clk);
      if (k < 3) chk("t5_gnt", gnt, 32'(1) << k);
      if (k >= 3 && k <= 9) chk("t5_gnt_off", gnt, 0);
      if (k == 10) chk("t5_gnt_resume", gnt, 4'b1000);
      if (k >= 4 && k <= 6) begin
        chk("t5_rsp_valid", rsp_valid, 1);
        chk("t5_rsp_id", rsp_id, k - 4);
      end
      if (k == 6) chk("t5_idle_busy", idle, 0);
      if (k == 7) chk("t5_idle", idle, 1);
    end
    repeat (6) next();

    // Fairness: requester 1 held, requester 3 pulsed
    for (int k = 0; k < 6; k++) begin
      next();
      req = (k == 5) ? 4'b0000 : ((k % 2 == 1) ? 4'b1010 : 4'b0010);
      @(negedge clk);
      chk("t6_gnt", gnt, (k == 5) ? 0 : ((k % 2 == 1) ? 32'h8 : 32'h2));
    end
    repeat (6) next();

    // Mid-stream reset with two reads in flight
    for (int k = 0; k < 12; k++) begin
      next();
      case (k)
        0: req = 4'b0001;
        1: req = 4'b0100;
        2: begin req = '0; reset = 1'b0; end
        4: reset = 1'b1;
        5: req = 4'b0101;
        6: req = 4'b0100;
        7: req = '0;
        default: ;
      endcase
      @(negedge clk);
      if (k == 0) chk("t7_gnt0", gnt, 4'b0001);
      if (k == 1) chk("t7_gnt2", gnt, 4'b0100);
      if (k == 2) begin
        chk("t7_rst_mre", mem_read_enable, 0);
        chk("t7_rst_idle", idle, 1);
        chk("t7_rst_gnt", gnt, 0);
      end
      if (k >= 2 && k <= 6) chk("t7_no_rsp", rsp_valid, 0);
      if (k == 5) chk("t7_post_gnt0", gnt, 4'b0001);
      if (k == 6) chk("t7_post_gnt2", gnt, 4'b0100);
      if (k == 9) begin chk("t7_rsp_a", rsp_valid, 1); chk("t7_rsp_a_id", rsp_id, 0); end
      if (k == 10) begin chk("t7_rsp_b", rsp_valid, 1); chk("t7_rsp_b_id", rsp_id, 2); end
    end
    repeat (4) next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_read_arbiter.md
Name: sprite_read_arbiter

Overview:
- Shares the single sprite-memory read port (element select, address, palette-resolved 12-bit colour) among several pixel requesters: background, fruit, heart, block and snake draw engines.
- Round-robin arbitration issues one read per clock.
- Each read carries a requester tag through the fixed memory latency.
- Each requester gets its colour back with its ID, or an error flag for an illegal element.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ELEM_W, 3: element-select width.
- ADDR_W, 10: sprite address width.
- DATA_W, 12: colour data width.
- NUM_ELEMENTS, 5: legal element IDs are 1..NUM_ELEMENTS.
- MEM_LATENCY, 2: cycles from a mem_read_enable cycle to valid mem_dataout (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = grant new requests; 0 = stop granting and drain.
- req  in  NUM_REQ  per-requester read request, held until granted.
- req_element  in  NUM_REQ*ELEM_W  packed element ID; requester i uses slice i.
- req_address  in  NUM_REQ*ADDR_W  packed sprite address; requester i uses slice i.
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the request.
- mem_read_enable  out  1  registered read strobe to sprite memory.
- mem_element  out  ELEM_W  registered element select.
- mem_address  out  ADDR_W  registered address.
- mem_dataout  in  DATA_W  colour from sprite memory.
- rsp_valid  out  1  response valid, one-cycle pulse per grant.
- rsp_id  out  clog2(NUM_REQ)  requester index of the response.
- rsp_err  out  1  1 = illegal element; rsp_data is 0.
- rsp_data  out  DATA_W  returned colour.
- idle  out  1  FSM idle and no reads in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - gnt, mem_*, rsp_* all 0; idle=1.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Tag pipeline cleared. In-flight reads are discarded and never responded to.
- FSM states IDLE, RUN, DRAIN:
  - IDLE->RUN when enable=1.
  - RUN->IDLE when enable=0 and pipeline empty.
  - RUN->DRAIN when enable=0 and pipeline non-empty.
  - DRAIN->IDLE when pipeline empty.
  - DRAIN->RUN when enable=1.
  - gnt can only assert in RUN.
  - idle is registered; it is 1 in IDLE only.
- Arbitration:
  - Search starts at pointer+1, modulo NUM_REQ. The first asserted req wins.
  - Pointer updates to the winner only on a grant.
  - At most one grant per cycle, so continuous throughput is 1 read/cycle.
  - A requester may drop or change req in the cycle after its gnt.
- Issue:
  - Grant in cycle T puts that requester's element and address on mem_element/mem_address at T+1, with mem_read_enable=1.
  - With no grant, mem_read_enable=0 and mem_element/mem_address hold their previous values.
- Illegal element (0 or >NUM_ELEMENTS):
  - Still granted and tagged; mem_read_enable stays 0 at T+1.
  - Response still produced at the normal latency with rsp_err=1 and rsp_data=0.
- Response path:
  - A shift register of depth MEM_LATENCY+1 carries {valid, id, err} per issue slot.
  - mem_dataout is sampled at T+1+MEM_LATENCY.
  - rsp_valid, rsp_id, rsp_err, rsp_data are registered at T+2+MEM_LATENCY; T+4 at default.
  - rsp_* are 0 when rsp_valid=0.
- Ordering: responses return in grant order, with no reordering or backpressure. Consumers must accept every rsp_valid pulse.
- Pipeline empty means no valid bit set in the tag shift register.
- enable falling in the same cycle as a req: no grant that cycle.

Decomposition:
- Package sprite_pkg holds:
  - element ID constants: ELEM_FRUIT=1, ELEM_HEART=2, ELEM_SNAKE=3, ELEM_BACKGROUND=4, ELEM_BLOCK=5.
  - NUM_ELEMENTS, the ELEM_W/ADDR_W/DATA_W defaults, and the FSM state encodings.
- One sub-module, rr_arbiter: parameterised NUM_REQ, taking req and pointer, returning a one-hot grant and the winner index.

Test Plan:
- Single read: req[0]=1, element 1, addr 10'h005, memory model returns 12'hF00 -> gnt[0] at T0; mem_read_enable=1, element 1, addr 5 at T1; at T4 rsp_valid=1, rsp_id=0, rsp_err=0, rsp_data=12'hF00.
- Full contention: req=4'b1111 held 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3 on consecutive cycles; rsp_id follows the same sequence starting 4 cycles later with no gaps.
- Illegal element: req[2] with element 0, then element 6 -> mem_read_enable=0 in both issue cycles; two responses with rsp_id=2, rsp_err=1, rsp_data=0 at T+4.
- Drain: 3 reads granted, then enable=0 -> no further gnt; 3 responses delivered; idle=1 the cycle after the pipeline empties; enable=1 -> grants resume.
- Mid-stream reset: reset=0 with 2 reads in flight -> all outputs 0 immediately, no responses for those reads. After release, req[0] and req[2] both asserted -> gnt[0] first, then gnt[2].
- Fairness: req[1] held continuously, req[3] pulsed -> grants alternate 1,3,1; no requester starves.
